// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master transmit path.
//   DEFAULT_FRAME_BITS : default word length shared with the SPI slave
//   spi_state_t        : master FSM states
//   spi_word_t         : one frame word at the default length
package spi_pkg;

    localparam int unsigned DEFAULT_FRAME_BITS = 32;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        GAP
    } spi_state_t;

    typedef logic [DEFAULT_FRAME_BITS-1:0] spi_word_t;

endpackage

// File: rtl/spi_sck_gen.sv
// SPI clock generator: divides clk into sck half-periods of CLK_DIV cycles.
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-low reset
//   start     in   frame accepted; restart the divider with sck low
//   run       in   frame in progress (FSM in LOW or HIGH)
//   sck       out  registered SPI clock, idles low
//   rise_tick out  high in the cycle whose closing clk edge raises sck
//   fall_tick out  high in the cycle whose closing clk edge lowers sck
module spi_sck_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic run,
    output logic sck,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          sck_q, sck_d;
    logic          div_done;

    always_comb begin
        div_done  = run && (div_cnt_q == DIV_LAST);
        // Strobes lead the sck edge by one cycle so the FSM acts on the same edge.
        rise_tick = div_done && !sck_q;
        fall_tick = div_done && sck_q;

        div_cnt_d = div_cnt_q;
        sck_d     = sck_q;
        if (start || !run) begin
            div_cnt_d = '0;
            sck_d     = 1'b0;
        end else if (div_done) begin
            div_cnt_d = '0;
            sck_d     = !sck_q;
        end else begin
            div_cnt_d = div_cnt_q + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_q <= '0;
            sck_q     <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            sck_q     <= sck_d;
        end
    end

    assign sck = sck_q;

endmodule

// File: rtl/spi_master_tx.sv
// SPI master: sends FRAME_BITS-bit words MSB-first on sdo and captures the
// word returned on sdi. sck idles low, sdo changes after sck falls, sdi is
// sampled as sck rises; no chip-select, frames are delimited by bit count.
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-low reset
//   tx_data   in   word to send, sampled on acceptance
//   tx_valid  in   tx_data valid
//   tx_ready  out  a frame can be accepted
//   rx_data   out  last word received, held until the next frame completes
//   rx_valid  out  one-cycle pulse when rx_data updates
//   busy      out  frame or inter-frame gap in progress
//   sck       out  registered SPI clock
//   sdo       out  registered serial data to slave
//   sdi       in   serial data from slave
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned FRAME_BITS = DEFAULT_FRAME_BITS,
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [FRAME_BITS-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  sck,
    output logic                  sdo,
    input  logic                  sdi
);

    localparam int unsigned BW = $clog2(FRAME_BITS);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    spi_state_t            state_q, state_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
    logic [FRAME_BITS-1:0] tx_sr_q, tx_sr_d;
    logic [FRAME_BITS-1:0] rx_sr_q, rx_sr_d;
    logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  tx_ready_q, tx_ready_d;

    logic accept;
    logic run;
    logic rise_tick;
    logic fall_tick;

    assign accept = tx_valid && tx_ready_q;
    assign run    = (state_q == LOW) || (state_q == HIGH);

    spi_sck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sck_gen (
        .clk      (clk),
        .reset    (reset),
        .start    (accept),
        .run      (run),
        .sck      (sck),
        .rise_tick(rise_tick),
        .fall_tick(fall_tick)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    tx_sr_d   = tx_data;
                    bit_cnt_d = '0;
                    state_d   = LOW;
                end
            end
            LOW: begin
                if (rise_tick) begin
                    rx_sr_d = {rx_sr_q[FRAME_BITS-2:0], sdi};
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (fall_tick) begin
                    if (bit_cnt_q != BIT_LAST) begin
                        tx_sr_d   = {tx_sr_q[FRAME_BITS-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        state_d   = LOW;
                    end else begin
                        // Last bit stays on sdo through the gap.
                        rx_data_d  = rx_sr_q;
                        rx_valid_d = 1'b1;
                        gap_cnt_d  = '0;
                        state_d    = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered so tx_ready stays low while reset is asserted.
        tx_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    // MSB of the shift register is the bit currently on the wire.
    assign sdo      = tx_sr_q[FRAME_BITS-1];
    assign tx_ready = tx_ready_q;
    assign busy     = (state_q != IDLE);
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: a behavioural SPI slave model plus a scoreboard of
// expected slave-received words and expected rx_data words. A second instance
// with CLK_DIV=2, GAP_CYCLES=1 runs a loopback frame for timing checks.
module tb_spi_master_tx;

    localparam int FB  = 32;
    localparam int DIV = 4;
    localparam int GAP = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [FB-1:0] tx_data  = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [FB-1:0] rx_data;
    logic          rx_valid;
    logic          busy;
    logic          sck;
    logic          sdo;
    logic          sdi;

    logic [FB-1:0] tx_data2  = '0;
    logic          tx_valid2 = 1'b0;
    logic          tx_ready2;
    logic [FB-1:0] rx_data2;
    logic          rx_valid2;
    logic          busy2;
    logic          sck2;
    logic          sdo2;
    logic          sdi2;

    spi_master_tx #(
        .CLK_DIV   (DIV),
        .FRAME_BITS(FB),
        .GAP_CYCLES(GAP)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .busy    (busy),
        .sck     (sck),
        .sdo     (sdo),
        .sdi     (sdi)
    );

    spi_master_tx #(
        .CLK_DIV   (2),
        .FRAME_BITS(FB),
        .GAP_CYCLES(1)
    ) u_dut2 (
        .clk     (clk),
        .reset   (reset),
        .tx_data (tx_data2),
        .tx_valid(tx_valid2),
        .tx_ready(tx_ready2),
        .rx_data (rx_data2),
        .rx_valid(rx_valid2),
        .busy    (busy2),
        .sck     (sck2),
        .sdo     (sdo2),
        .sdi     (sdi2)
    );

    assign sdi2 = sdo2;

    int nchecks = 0;
    int nfail   = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [FB-1:0] act, input logic [FB-1:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic report_fail(input string name);
        nchecks++;
        nfail++;
        $display("FAIL %s: event did not occur within budget (cycle %0d)", name, cyc);
    endtask

    // Scoreboard: words the slave must see, and words rx_data must show.
    logic [FB-1:0] exp_tx_q[$];
    logic [FB-1:0] exp_rx_q[$];
    logic [FB-1:0] resp_q[$];
    int acc_cyc      = 0;
    int last_rxv_cyc = 0;
    int frame_rises  = 0;

    // Slave model: samples sdo on sck rise, presents the next response bit
    // after sck fall, one response word per frame of FB bits.
    int            s_cnt = 0;
    logic [FB-1:0] s_rx  = '0;
    logic          s_sdi = 1'b0;
    assign sdi = s_sdi;

    task automatic slave_update();
        logic [FB-1:0] w;
        if (s_cnt < FB && resp_q.size() > 0) begin
            w     = resp_q[0];
            s_sdi = w[FB-1-s_cnt];
        end else begin
            s_sdi = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(sck);
            if (reset) begin
                if (sck) begin
                    s_rx = {s_rx[FB-2:0], sdo};
                    s_cnt++;
                    frame_rises++;
                    if (s_cnt == FB) begin
                        if (exp_tx_q.size() == 0) report_fail("slave_frame_unexpected");
                        else chk("slave_rx_word", s_rx, exp_tx_q.pop_front());
                    end
                end else begin
                    if (s_cnt == FB) begin
                        if (resp_q.size() > 0) void'(resp_q.pop_front());
                        s_cnt = 0;
                    end
                    slave_update();
                end
            end
        end
    end

    // Monitor on the rx side of the main instance.
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                prev = 1'b0;
            end else begin
                if (prev) begin
                    chk("rx_valid_pulse_width", {31'b0, rx_valid}, '0);
                end else if (rx_valid) begin
                    if (exp_rx_q.size() == 0) report_fail("rx_valid_unexpected");
                    else chk("rx_data", rx_data, exp_rx_q.pop_front());
                    chk("rx_valid_latency", cyc - acc_cyc, 2 * DIV * FB);
                    chk("sck_rises_per_frame", frame_rises, FB);
                    last_rxv_cyc = cyc;
                end
                prev = rx_valid;
            end
        end
    end

    task automatic send(input logic [FB-1:0] w, input logic [FB-1:0] r);
        int n;
        n = 0;
        exp_tx_q.push_back(w);
        exp_rx_q.push_back(r);
        resp_q.push_back(r);
        slave_update();
        tx_data  = w;
        tx_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_ready && n < 3000);
        if (!tx_ready) begin
            report_fail("accept_timeout");
            tx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc_cyc     = cyc;
        frame_rises = 0;
        tx_valid    = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_rx_q.size() > 0 || exp_tx_q.size() > 0 || busy) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 5000) report_fail("drain_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
        nfail++;
        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acc2;
        int rises;
        int last_rise;
        int last_fall;
        bit got;
        logic prev_sck;

        // Reset held with tx_valid high: nothing may move.
        reset    = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 32'h1234_5678;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("reset_ctrl_outputs", {27'b0, sck, sdo, rx_valid, busy, tx_ready}, '0);
            chk("reset_rx_data", rx_data, '0);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("tx_ready_after_release", {31'b0, tx_ready}, 32'd1);
        chk("busy_after_release", {31'b0, busy}, '0);
        tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Single frame with fixed words.
        send(32'h0000_02A5, 32'hDEAD_BEEF);
        drain();

        // Back-to-back: second acceptance GAP+1 cycles after rx_valid.
        send(32'h1111_1111, 32'h0BAD_F00D);
        send(32'h2222_2222, 32'hCAFE_0001);
        chk("b2b_accept_spacing", acc_cyc - last_rxv_cyc, GAP + 1);
        drain();

        // New word presented mid-frame waits for the current one.
        send(32'h5A5A_1234, 32'h8765_4321);
        repeat (60) @(posedge clk);
        #1;
        send(32'hFFFF_FFFF, 32'h0F0F_F0F0);
        chk("backpressure_accept_spacing", acc_cyc - last_rxv_cyc, GAP + 1);
        drain();

        // Random words, random spacing (some overlap an active frame).
        for (int i = 0; i < 6; i++) begin
            send($urandom, $urandom);
            repeat ($urandom_range(0, 300)) @(posedge clk);
            #1;
        end
        drain();

        // Reset in the middle of a frame.
        send(32'hC3C3_0F0F, $urandom);
        n = 0;
        while (frame_rises < 10 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (frame_rises < 10) report_fail("tenth_rise_timeout");
        chk("sck_high_before_reset", {31'b0, sck}, 32'd1);
        reset = 1'b0;
        #1;
        chk("sck_async_drop", {31'b0, sck}, '0);
        chk("busy_async_drop", {31'b0, busy}, '0);
        exp_tx_q.delete();
        exp_rx_q.delete();
        resp_q.delete();
        s_cnt = 0;
        s_rx  = '0;
        slave_update();
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rx_valid_in_reset", {31'b0, rx_valid}, '0);
        end
        @(negedge clk);
        reset = 1'b1;
        send(32'h0000_003C, 32'h5A0F_96E1);
        drain();

        // CLK_DIV=2, GAP_CYCLES=1 loopback instance.
        tx_data2  = 32'hA5A5_A5A5;
        tx_valid2 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_ready2 && n < 100);
        if (!tx_ready2) report_fail("dut2_accept_timeout");
        @(posedge clk);
        #1;
        acc2      = cyc;
        tx_valid2 = 1'b0;
        prev_sck  = sck2;
        rises     = 0;
        last_rise = 0;
        last_fall = 0;
        got       = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(posedge clk);
            #1;
            if (sck2 && !prev_sck) begin
                if (rises == 0) chk("dut2_first_rise", cyc - acc2, 2);
                else chk("dut2_sck_period", cyc - last_rise, 4);
                last_rise = cyc;
                rises++;
            end
            if (!sck2 && prev_sck) last_fall = cyc;
            if (rx_valid2) begin
                got = 1'b1;
                chk("dut2_loopback_rx_data", rx_data2, 32'hA5A5_A5A5);
            end
            prev_sck = sck2;
        end
        if (!got) report_fail("dut2_rx_valid_timeout");
        chk("dut2_sck_rises", rises, FB);
        chk("dut2_final_fall_edge", last_fall - acc2, 128);

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
